// File: rtl/vga_board_renderer.sv
// N x N board renderer between the VGA timing controller and the pins. It holds the
// cell state, drives a 1-cycle sprite ROM and outputs colour/syncs with a fixed 3-cycle latency.
module vga_board_renderer #(
    parameter int BOARD_N    = 3,
    parameter int CELL_SIZE  = 150,
    parameter int STRIPE_W   = 5,
    parameter int CURSOR_W   = 3,
    parameter int ORIGIN_X   = 95,
    parameter int ORIGIN_Y   = 15,
    parameter int COL_WIDTH  = 10,
    parameter int ROW_WIDTH  = 10,
    parameter int IDX_WIDTH  = 3,
    parameter int ADDR_WIDTH = 15,
    parameter int BLINK_BITS = 25
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic [COL_WIDTH-1:0]       iPixelCol,
    input  logic [ROW_WIDTH-1:0]       iPixelRow,
    input  logic                       iDisplayOn,
    input  logic                       iHSync,
    input  logic                       iVSync,
    input  logic                       iCellWrEn,
    input  logic [IDX_WIDTH-1:0]       iCellWrX,
    input  logic [IDX_WIDTH-1:0]       iCellWrY,
    input  logic [1:0]                 iCellWrSym,
    input  logic                       iClearBoard,
    input  logic [IDX_WIDTH-1:0]       iCursorX,
    input  logic [IDX_WIDTH-1:0]       iCursorY,
    input  logic                       iWinFlag,
    input  logic [BOARD_N*BOARD_N-1:0] iWinMask,
    output logic [ADDR_WIDTH-1:0]      oSpriteAddr,
    output logic                       oSpriteSel,
    input  logic                       iSpritePixel,
    output logic [2:0]                 oVGAColor,
    output logic                       oVGAHorizontalSync,
    output logic                       oVGAVerticalSync,
    output logic                       oWrReject,
    output logic                       oBoardFull
);
    localparam int CELLS  = BOARD_N * BOARD_N;
    localparam int SPAN   = BOARD_N * CELL_SIZE;
    localparam int HALF_W = STRIPE_W / 2;

    localparam logic [1:0] SYM_EMPTY = 2'b00;
    localparam logic [1:0] SYM_X     = 2'b01;
    localparam logic [1:0] SYM_O     = 2'b10;

    localparam logic [2:0] C_BLACK   = 3'b000;
    localparam logic [2:0] C_BLUE    = 3'b001;
    localparam logic [2:0] C_GREEN   = 3'b010;
    localparam logic [2:0] C_CYAN    = 3'b011;
    localparam logic [2:0] C_MAGENTA = 3'b101;
    localparam logic [2:0] C_YELLOW  = 3'b110;

    typedef struct packed {
        logic       vis;
        logic       cursor;
        logic       stripe;
        logic       sym_on;
        logic [2:0] sym_color;
        logic       hs;
        logic       vs;
    } stage_t;

    localparam stage_t STAGE_RST = '{vis: 1'b0, cursor: 1'b0, stripe: 1'b0, sym_on: 1'b0,
                                     sym_color: 3'b000, hs: 1'b1, vs: 1'b1};

    logic [CELLS-1:0][1:0]   board_q, board_d;
    logic                    wr_reject_q, wr_reject_d;
    logic                    full_q, full_d;
    logic [BLINK_BITS-1:0]   blink_q, blink_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    sel_q, sel_d;
    stage_t                  s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic                    pix_q, pix_d;
    logic [2:0]              color_q, color_d;
    logic                    hsync_q, hsync_d, vsync_q, vsync_d;

    int                      fc, fr, loc_x, loc_y;
    logic [IDX_WIDTH-1:0]    cell_x, cell_y;
    logic                    in_board, on_stripe, on_cursor, cell_win;
    logic [1:0]              cell_sym;
    logic                    wr_ok, wr_legal_sym, wr_in_range;

    // Cell decomposition uses a constant comparator chain instead of a divider.
    // NOTE: every signal written in an always_comb gets a default first, so no latch can form.
    always_comb begin
        fc        = int'(iPixelCol) - ORIGIN_X;
        fr        = int'(iPixelRow) - ORIGIN_Y;
        cell_x    = '0;
        cell_y    = '0;
        loc_x     = fc;
        loc_y     = fr;
        on_stripe = 1'b0;
        for (int k = 1; k < BOARD_N; k++) begin
            if (fc >= k * CELL_SIZE) begin
                cell_x = IDX_WIDTH'(k);
                loc_x  = fc - k * CELL_SIZE;
            end
            if (fr >= k * CELL_SIZE) begin
                cell_y = IDX_WIDTH'(k);
                loc_y  = fr - k * CELL_SIZE;
            end
            if ((fc >= k * CELL_SIZE - HALF_W && fc <= k * CELL_SIZE + HALF_W) ||
                (fr >= k * CELL_SIZE - HALF_W && fr <= k * CELL_SIZE + HALF_W))
                on_stripe = 1'b1;
        end
        in_board  = (fc >= 0) && (fc < SPAN) && (fr >= 0) && (fr < SPAN);
        on_cursor = (cell_x == iCursorX) && (cell_y == iCursorY) &&
                    (loc_x < CURSOR_W || loc_x > CELL_SIZE - 1 - CURSOR_W ||
                     loc_y < CURSOR_W || loc_y > CELL_SIZE - 1 - CURSOR_W);
        cell_sym  = SYM_EMPTY;
        cell_win  = 1'b0;
        for (int c = 0; c < CELLS; c++) begin
            if (int'(cell_y) * BOARD_N + int'(cell_x) == c) begin
                cell_sym = board_q[c];
                cell_win = iWinMask[c];
            end
        end
    end

    // S1 looks up geometry and symbol; S2/S3 wait out the ROM; the output stage resolves priority.
    always_comb begin
        s1_d    = STAGE_RST;
        s1_d.hs = iHSync;
        s1_d.vs = iVSync;
        addr_d  = '0;
        sel_d   = 1'b0;
        if (in_board) begin
            addr_d      = ADDR_WIDTH'(loc_x + CELL_SIZE * loc_y);
            sel_d       = (cell_sym == SYM_O);
            s1_d.vis    = iDisplayOn;
            s1_d.cursor = on_cursor;
            s1_d.stripe = on_stripe;
            s1_d.sym_on = (cell_sym == SYM_X) || (cell_sym == SYM_O);
            if (iWinFlag && cell_win && !blink_q[BLINK_BITS-1])
                s1_d.sym_color = C_GREEN;
            else if (cell_sym == SYM_O)
                s1_d.sym_color = C_YELLOW;
            else
                s1_d.sym_color = C_BLUE;
        end
        s2_d    = s1_q;
        s3_d    = s2_q;
        pix_d   = iSpritePixel;
        color_d = C_BLACK;
        if (s3_q.vis) begin
            if (s3_q.cursor)
                color_d = C_CYAN;
            else if (s3_q.stripe)
                color_d = C_MAGENTA;
            else if (s3_q.sym_on && pix_q)
                color_d = s3_q.sym_color;
        end
        hsync_d = s3_q.hs;
        vsync_d = s3_q.vs;
        blink_d = blink_q + 1'b1;
    end

    // Writes are write-once; clear wins over a same-cycle write and never raises a reject.
    always_comb begin
        board_d      = board_q;
        full_d       = 1'b1;
        wr_ok        = 1'b0;
        wr_legal_sym = (iCellWrSym == SYM_X) || (iCellWrSym == SYM_O);
        wr_in_range  = (int'(iCellWrX) < BOARD_N) && (int'(iCellWrY) < BOARD_N);
        for (int c = 0; c < CELLS; c++) begin
            if (board_q[c] == SYM_EMPTY)
                full_d = 1'b0;
            if (iCellWrEn && !iClearBoard && wr_legal_sym && wr_in_range &&
                int'(iCellWrY) * BOARD_N + int'(iCellWrX) == c && board_q[c] == SYM_EMPTY) begin
                board_d[c] = iCellWrSym;
                wr_ok      = 1'b1;
            end
        end
        if (iClearBoard)
            board_d = '0;
        wr_reject_d = iCellWrEn && !iClearBoard && !wr_ok;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            // NOTE: the board is a small register file, reset so every cell starts empty.
            board_q     <= '0;
            wr_reject_q <= 1'b0;
            full_q      <= 1'b0;
            blink_q     <= '0;
            addr_q      <= '0;
            sel_q       <= 1'b0;
            s1_q        <= STAGE_RST;
            s2_q        <= STAGE_RST;
            s3_q        <= STAGE_RST;
            pix_q       <= 1'b0;
            color_q     <= C_BLACK;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
        end else begin
            board_q     <= board_d;
            wr_reject_q <= wr_reject_d;
            full_q      <= full_d;
            blink_q     <= blink_d;
            addr_q      <= addr_d;
            sel_q       <= sel_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            pix_q       <= pix_d;
            color_q     <= color_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
        end
    end

    assign oSpriteAddr        = addr_q;
    assign oSpriteSel         = sel_q;
    assign oVGAColor          = color_q;
    assign oVGAHorizontalSync = hsync_q;
    assign oVGAVerticalSync   = vsync_q;
    assign oWrReject          = wr_reject_q;
    assign oBoardFull         = full_q;
endmodule

// File: tb/tb_vga_board_renderer.sv
// Directed bench for vga_board_renderer: a 3x3 board with a short blink timer,
// plus a 4x4 / 100-pixel instance for the parameter variant.
module tb_vga_board_renderer;
    localparam logic [2:0] BLACK = 3'b000, BLUE = 3'b001, GREEN = 3'b010,
                           CYAN = 3'b011, MAGENTA = 3'b101, YELLOW = 3'b110;
    localparam logic [1:0] SX = 2'b01, SO = 2'b10;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [9:0]  iPixelCol, iPixelRow;
    logic        iDisplayOn, iHSync, iVSync;
    logic        iCellWrEn, iCellWrEn4;
    logic [2:0]  iCellWrX, iCellWrY, iCursorX, iCursorY;
    logic [1:0]  iCellWrSym;
    logic        iClearBoard, iWinFlag, iSpritePixel;
    logic [8:0]  iWinMask;
    logic [15:0] iWinMask4;

    logic [14:0] oSpriteAddr, oSpriteAddr4;
    logic        oSpriteSel, oSpriteSel4;
    logic [2:0]  oVGAColor, oVGAColor4;
    logic        oHS, oVS, oHS4, oVS4;
    logic        oWrReject, oWrReject4, oBoardFull, oBoardFull4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clock = ~Clock;

    vga_board_renderer #(.BLINK_BITS(4)) u_dut (
        .Clock(Clock), .Reset(Reset), .iPixelCol(iPixelCol), .iPixelRow(iPixelRow),
        .iDisplayOn(iDisplayOn), .iHSync(iHSync), .iVSync(iVSync),
        .iCellWrEn(iCellWrEn), .iCellWrX(iCellWrX), .iCellWrY(iCellWrY),
        .iCellWrSym(iCellWrSym), .iClearBoard(iClearBoard),
        .iCursorX(iCursorX), .iCursorY(iCursorY), .iWinFlag(iWinFlag), .iWinMask(iWinMask),
        .oSpriteAddr(oSpriteAddr), .oSpriteSel(oSpriteSel), .iSpritePixel(iSpritePixel),
        .oVGAColor(oVGAColor), .oVGAHorizontalSync(oHS), .oVGAVerticalSync(oVS),
        .oWrReject(oWrReject), .oBoardFull(oBoardFull)
    );

    vga_board_renderer #(.BOARD_N(4), .CELL_SIZE(100), .BLINK_BITS(4)) u_dut4 (
        .Clock(Clock), .Reset(Reset), .iPixelCol(iPixelCol), .iPixelRow(iPixelRow),
        .iDisplayOn(iDisplayOn), .iHSync(iHSync), .iVSync(iVSync),
        .iCellWrEn(iCellWrEn4), .iCellWrX(iCellWrX), .iCellWrY(iCellWrY),
        .iCellWrSym(iCellWrSym), .iClearBoard(iClearBoard),
        .iCursorX(iCursorX), .iCursorY(iCursorY), .iWinFlag(iWinFlag), .iWinMask(iWinMask4),
        .oSpriteAddr(oSpriteAddr4), .oSpriteSel(oSpriteSel4), .iSpritePixel(iSpritePixel),
        .oVGAColor(oVGAColor4), .oVGAHorizontalSync(oHS4), .oVGAVerticalSync(oVS4),
        .oWrReject(oWrReject4), .oBoardFull(oBoardFull4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic pixel(input int col, input int row, input logic pix);
        iPixelCol    = 10'(col);
        iPixelRow    = 10'(row);
        iSpritePixel = pix;
    endtask

    task automatic cursor(input int x, input int y);
        iCursorX = 3'(x);
        iCursorY = 3'(y);
    endtask

    // Pixel drawn with inputs held long enough to flush the pipeline.
    task automatic show(input string tag, input int col, input int row, input logic pix,
                        input logic [2:0] exp);
        pixel(col, row, pix);
        tick(5);
        check(tag, oVGAColor, exp);
    endtask

    task automatic wr(input string tag, input int x, input int y, input logic [1:0] sym,
                      input logic exp_rej);
        iCellWrX   = 3'(x);
        iCellWrY   = 3'(y);
        iCellWrSym = sym;
        iCellWrEn  = 1'b1;
        tick(1);
        iCellWrEn  = 1'b0;
        check(tag, oWrReject, exp_rej);
    endtask

    initial begin
        logic [11:0] hp;
        logic [11:0] vp;
        logic [2:0]  prev;
        logic [2:0]  v;
        bit          seen;
        hp = 12'b1011_0011_1010;
        vp = 12'b0110_1100_0101;

        Reset = 1'b0;
        iDisplayOn = 1'b1; iHSync = 1'b1; iVSync = 1'b1;
        iCellWrEn = 1'b0; iCellWrEn4 = 1'b0; iCellWrX = '0; iCellWrY = '0; iCellWrSym = '0;
        iClearBoard = 1'b0; iWinFlag = 1'b0; iWinMask = '0; iWinMask4 = '0;
        cursor(0, 0);
        pixel(96, 20, 1'b0);
        tick(2);
        Reset = 1'b1;

        // Reset in the middle of a drawn cursor pixel, then release and track latency.
        tick(6);
        check("pre_reset_cyan", oVGAColor, CYAN);
        iHSync = 1'b0; iVSync = 1'b0;
        Reset = 1'b0;
        #1;
        check("rst_color", oVGAColor, BLACK);
        check("rst_syncs", {oHS, oVS}, 2'b11);
        check("rst_full", oBoardFull, 1'b0);
        check("rst_addr", oSpriteAddr, 15'd0);
        check("rst_reject", oWrReject, 1'b0);
        tick(2);
        check("rst_hold_color", oVGAColor, BLACK);
        #3;
        Reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            iHSync = hp[i];
            iVSync = vp[i];
            tick(1);
            if (i == 2) check("rel_black_e2", oVGAColor, BLACK);
            if (i == 3) check("rel_cyan_e3", oVGAColor, CYAN);
            if (i >= 3) check($sformatf("hsync_d3_%0d", i), oHS, hp[i-3]);
            if (i >= 3) check($sformatf("vsync_d3_%0d", i), oVS, vp[i-3]);
        end
        iHSync = 1'b1; iVSync = 1'b1;

        // X at (1,1): address at S1, colour three cycles after S1.
        wr("wr_x11", 1, 1, SX, 1'b0);
        pixel(320, 240, 1'b1);
        tick(1);
        check("x11_addr", oSpriteAddr, 15'd11325);
        check("x11_sel", oSpriteSel, 1'b0);
        tick(2);
        check("x11_latency_old", oVGAColor, CYAN);
        tick(1);
        check("x11_blue", oVGAColor, BLUE);
        show("x11_pix0", 320, 240, 1'b0, BLACK);

        // Cursor, stripe, priority and board edges.
        cursor(0, 0);
        show("cursor_cyan", 96, 20, 1'b0, CYAN);
        show("cursor_over_stripe", 243, 20, 1'b0, CYAN);
        cursor(2, 2);
        show("stripe_col", 243, 20, 1'b0, MAGENTA);
        show("stripe_edge_in", 247, 20, 1'b0, MAGENTA);
        show("stripe_edge_out", 248, 20, 1'b0, BLACK);
        show("stripe_row", 320, 317, 1'b0, MAGENTA);
        show("stripe_over_sym", 245, 240, 1'b1, MAGENTA);
        show("outer_edge", 544, 90, 1'b0, BLACK);
        cursor(0, 0);
        show("left_of_board", 94, 20, 1'b0, BLACK);
        iDisplayOn = 1'b0;
        show("display_off", 96, 20, 1'b0, BLACK);
        iDisplayOn = 1'b1;
        cursor(3, 0);
        show("cursor_out_of_range", 96, 20, 1'b0, BLACK);

        // Write-once, out-of-range and illegal symbols.
        wr("wr_o20", 2, 0, SO, 1'b0);
        wr("wr_x20_dup", 2, 0, SX, 1'b1);
        tick(1);
        check("reject_one_cycle", oWrReject, 1'b0);
        wr("wr_30_range", 3, 0, SX, 1'b1);
        wr("wr_sym11", 0, 2, 2'b11, 1'b1);
        wr("wr_sym00", 0, 2, 2'b00, 1'b1);
        cursor(0, 0);
        show("o20_yellow", 470, 90, 1'b1, YELLOW);
        check("o20_sel", oSpriteSel, 1'b1);
        check("o20_addr", oSpriteAddr, 15'd11325);

        // Fill the board, then clear together with a write.
        wr("fill_00", 0, 0, SX, 1'b0);
        wr("fill_10", 1, 0, SO, 1'b0);
        wr("fill_01", 0, 1, SX, 1'b0);
        wr("fill_21", 2, 1, SO, 1'b0);
        wr("fill_02", 0, 2, SX, 1'b0);
        wr("fill_12", 1, 2, SO, 1'b0);
        check("not_full_yet", oBoardFull, 1'b0);
        wr("fill_22", 2, 2, SX, 1'b0);
        check("full_lags", oBoardFull, 1'b0);
        tick(1);
        check("full_set", oBoardFull, 1'b1);
        iClearBoard = 1'b1;
        wr("clear_with_write", 0, 0, SX, 1'b0);
        iClearBoard = 1'b0;
        tick(1);
        check("full_cleared", oBoardFull, 1'b0);
        show("cleared_cell_11", 320, 240, 1'b1, BLACK);
        wr("wr_after_clear", 0, 0, SX, 1'b0);

        // Win blink: green/blue runs of 8 cycles with a 4-bit timer.
        wr("wr_x11_win", 1, 1, SX, 1'b0);
        iWinFlag = 1'b1;
        iWinMask = 9'b000010000;
        pixel(320, 240, 1'b1);
        tick(5);
        prev = oVGAColor;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick(1);
            if (oVGAColor != prev) seen = 1'b1;
        end
        check("blink_toggle_seen", 32'(seen), 32'd1);
        v = oVGAColor;
        check("blink_value", 32'(v == GREEN || v == BLUE), 32'd1);
        for (int i = 1; i < 8; i++) begin
            tick(1);
            check($sformatf("blink_run_%0d", i), oVGAColor, v);
        end
        tick(1);
        check("blink_flip", oVGAColor, (v == GREEN) ? BLUE : GREEN);
        iWinFlag = 1'b0;
        show("no_win_blue", 320, 240, 1'b1, BLUE);

        // 4x4, 100-pixel variant.
        cursor(7, 7);
        pixel(395, 65, 1'b0);
        tick(5);
        check("n4_stripe_300", oVGAColor4, MAGENTA);
        pixel(445, 365, 1'b1);
        tick(1);
        check("n4_addr_33", oSpriteAddr4, 15'd5050);
        iCellWrX = 3'd3; iCellWrY = 3'd3; iCellWrSym = SX; iCellWrEn4 = 1'b1;
        tick(1);
        iCellWrEn4 = 1'b0;
        check("n4_wr_33", oWrReject4, 1'b0);
        tick(5);
        check("n4_x33_blue", oVGAColor4, BLUE);
        check("n4_not_full", oBoardFull4, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
